seg7_decode_monitor: RTL and testbench

Receive-side counterpart of the team's 7-segment digit drivers. It samples an 8-bit segment bus and filters out glitches with a stability window. It decodes each newly stable pattern back to a BCD digit. It also checks that accepted digits follow the modulo-10 up-count sequence (0,1,…,9,0), reporting illegal patterns and sequence breaks through pulses and a saturating error counter. It sits in testbench and self-check paths, fed by segment outputs that update on the falling clock edge.

---
 rtl/seg7_decode_monitor.sv | 119 +++++++++++
 tb/tb_seg7_decode_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_decode_monitor.sv
// Receive-side 7-segment monitor: debounces the segment bus, decodes stable
// patterns to BCD and checks the modulo-10 up-count sequence.
module seg7_decode_monitor #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           seg_in,
  input  logic                 en,
  input  logic                 clr_err,
  output logic [3:0]           digit,
  output logic                 digit_valid,
  output logic                 blank,
  output logic                 illegal,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);

  state_t     r_state;
  logic [7:0] r_prev;
  logic [7:0] r_acc;
  logic [3:0] r_cnt;
  logic [3:0] r_exp;

  logic [3:0] w_cnt_next;
  logic       w_accept;
  logic       w_legal;
  logic [3:0] w_dec;
  logic       w_blank_pat;
  logic       w_illegal;
  logic       w_seq_bad;
  logic       w_inc;
  logic [3:0] w_exp_next;

  // Run length of identical enabled samples, capped at the window size.
  always_comb begin
    w_cnt_next = 4'd1;
    if (r_cnt != '0 && seg_in == r_prev)
      w_cnt_next = (r_cnt >= LP_STABLE) ? r_cnt : r_cnt + 4'd1;
    w_accept = en && (w_cnt_next >= LP_STABLE) && (seg_in != r_acc);
  end

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 4'd0;
    case (seg_in)
      8'hFC: w_dec = 4'd0;
      8'h60: w_dec = 4'd1;
      8'hDA: w_dec = 4'd2;
      8'hF2: w_dec = 4'd3;
      8'h66: w_dec = 4'd4;
      8'hB6: w_dec = 4'd5;
      8'hBE: w_dec = 4'd6;
      8'hE0: w_dec = 4'd7;
      8'hFE: w_dec = 4'd8;
      8'hE6: w_dec = 4'd9;
      default: w_legal = 1'b0;
    endcase
    w_blank_pat = (seg_in == '0);
    w_illegal   = !w_legal && !w_blank_pat;
    w_seq_bad   = (r_state == LOCKED) && w_legal && (w_dec != r_exp);
    w_inc       = w_accept && (w_illegal || w_seq_bad);
    w_exp_next  = (w_dec == 4'd9) ? 4'd0 : w_dec + 4'd1;
  end

  assign locked = (r_state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_exp       <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      blank       <= 1'b1;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      if (!en) begin
        r_cnt   <= '0;
        r_state <= IDLE;
      end else begin
        r_cnt  <= w_cnt_next;
        r_prev <= seg_in;
        if (w_accept) begin
          r_acc <= seg_in;
          blank <= w_blank_pat;
          if (w_legal) begin
            digit       <= w_dec;
            digit_valid <= 1'b1;
            seq_err     <= w_seq_bad;
            r_exp       <= w_exp_next;
            r_state     <= LOCKED;
          end else begin
            illegal <= w_illegal;
            r_state <= IDLE;
          end
        end
      end
      if (clr_err)
        err_count <= '0;
      else if (w_inc && err_count != '1)
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Randomized bench for seg7_decode_monitor against a queue-based reference model.
module tb_seg7_decode_monitor;

  localparam int S    = 2;
  localparam int W    = 2;
  localparam int MAXE = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   seg_in = 8'h00;
  logic         en = 1'b1;
  logic         clr_err = 1'b0;
  logic [3:0]   digit;
  logic         digit_valid, blank, illegal, seq_err, locked;
  logic [W-1:0] err_count;

  seg7_decode_monitor #(.STABLE_CYCLES(S), .ERR_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .en(en), .clr_err(clr_err),
    .digit(digit), .digit_valid(digit_valid), .blank(blank), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [7:0] tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;
  int n_dv = 0, n_ill = 0, n_seq = 0;

  // Reference model state
  logic [7:0] hist [$];
  logic [7:0] m_acc;
  int         m_digit, m_exp, m_err;
  bit         m_dv, m_blank, m_ill, m_seq, m_locked;

  function automatic int dec(logic [7:0] p);
    for (int i = 0; i < 10; i++) if (tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_acc = 8'h00; m_digit = 0; m_exp = 0; m_err = 0;
    m_dv = 0; m_blank = 1; m_ill = 0; m_seq = 0; m_locked = 0;
  endtask

  task automatic model_step();
    int d;
    bit inc;
    inc = 0; m_dv = 0; m_ill = 0; m_seq = 0;
    if (!en) begin
      hist.delete();
      m_locked = 0;
    end else begin
      if (hist.size() > 0 && hist[$] != seg_in) hist.delete();
      hist.push_back(seg_in);
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() >= S && seg_in != m_acc) begin
        m_acc   = seg_in;
        m_blank = (seg_in == 8'h00);
        d = dec(seg_in);
        if (d >= 0) begin
          m_dv = 1; m_digit = d;
          if (m_locked && d != m_exp) begin m_seq = 1; inc = 1; end
          m_exp = (d + 1) % 10;
          m_locked = 1;
        end else if (seg_in != 8'h00) begin
          m_ill = 1; inc = 1; m_locked = 0;
        end else begin
          m_locked = 0;
        end
      end
    end
    if (clr_err) m_err = 0;
    else if (inc && m_err < MAXE) m_err++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("digit",       32'(digit),       32'(m_digit));
      chk("digit_valid", 32'(digit_valid), 32'(m_dv));
      chk("blank",       32'(blank),       32'(m_blank));
      chk("illegal",     32'(illegal),     32'(m_ill));
      chk("seq_err",     32'(seq_err),     32'(m_seq));
      chk("locked",      32'(locked),      32'(m_locked));
      chk("err_count",   32'(err_count),   32'(m_err));
      if (digit_valid === 1'b1) n_dv++;
      if (illegal === 1'b1)     n_ill++;
      if (seq_err === 1'b1)     n_seq++;
    end
  end

  // Called at a falling edge; covers n rising edges and returns on a falling edge.
  task automatic hold(logic [7:0] p, int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b, bs, bi, r, n, seqd;
    logic [7:0] p;
    model_reset();
    rst = 1'b0; en = 1'b1; seg_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_on = 1;
    #1;
    chk("rst_digit", 32'(digit), 0);
    chk("rst_blank", 32'(blank), 1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err_count), 0);
    @(negedge clk);

    // Asynchronous reset mid-sequence
    hold(8'hFC, 5);
    hold(8'h60, 3);
    #1 chk("pre_rst_digit", 32'(digit), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_locked", 32'(locked), 0);
    chk("async_digit", 32'(digit), 0);
    chk("async_blank", 32'(blank), 1);
    @(negedge clk);
    rst = 1'b1;
    b = n_dv; bs = n_seq;
    hold(8'hFC, 2);
    #1;
    chk("post_rst_dv", 32'(digit_valid), 1);
    chk("post_rst_locked", 32'(locked), 1);

    // Full count 0..9,0
    for (int i = 1; i <= 10; i++) hold(tab[i % 10], 3);
    #1;
    chk("count_dv", 32'(n_dv - b), 11);
    chk("count_seq", 32'(n_seq - bs), 0);
    chk("count_err", 32'(err_count), 0);
    chk("count_digit", 32'(digit), 0);

    // Glitch rejection
    b = n_dv; bi = n_ill;
    hold(8'hFC, 2);
    hold(8'h60, 1);
    hold(8'hFC, 3);
    #1;
    chk("glitch_dv", 32'(n_dv - b), 0);
    chk("glitch_ill", 32'(n_ill - bi), 0);
    chk("glitch_digit", 32'(digit), 0);

    // Sequence skip 3 -> 5, then 6
    hold(8'h60, 3); hold(8'hDA, 3); hold(8'hF2, 3);
    bs = n_seq;
    hold(8'hB6, 2);
    #1;
    chk("skip_pulse", 32'(seq_err), 1);
    chk("skip_err", 32'(err_count), 1);
    chk("skip_digit", 32'(digit), 5);
    b = n_dv;
    hold(8'hBE, 3);
    #1;
    chk("skip_next_dv", 32'(n_dv - b), 1);
    chk("skip_next_seq", 32'(n_seq - bs), 1);

    // Illegal pattern, then clear colliding with an increment
    hold(8'h01, 2);
    #1;
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_err", 32'(err_count), 2);
    chk("ill_locked", 32'(locked), 0);
    hold(8'h03, 1);
    clr_err = 1'b1;
    hold(8'h03, 1);
    clr_err = 1'b0;
    #1;
    chk("clr_pulse", 32'(illegal), 1);
    chk("clr_err", 32'(err_count), 0);

    // Saturation
    bi = n_ill;
    hold(8'h01, 2); hold(8'h03, 2); hold(8'h01, 2); hold(8'h03, 2); hold(8'h01, 2);
    #1;
    chk("sat_ill", 32'(n_ill - bi), 5);
    chk("sat_err", 32'(err_count), 3);

    // Enable gating
    b = n_dv;
    en = 1'b0;
    hold(8'hFC, 4);
    en = 1'b1;
    hold(8'hFC, 1);
    #1;
    chk("en_nodv", 32'(n_dv - b), 0);
    hold(8'hFC, 1);
    #1;
    chk("en_dv", 32'(digit_valid), 1);
    chk("en_digit", 32'(digit), 0);

    // Randomized traffic
    seqd = 1;
    repeat (1500) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin p = tab[seqd % 10]; seqd++; end
      else if (r < 7) p = tab[$urandom_range(0, 9)];
      else if (r == 7) p = 8'h00;
      else if (r == 8) p = 8'($urandom_range(0, 255));
      else p = tab[$urandom_range(0, 9)] | 8'h01;
      en = ($urandom_range(0, 19) != 0);
      clr_err = ($urandom_range(0, 29) == 0);
      n = $urandom_range(1, 4);
      hold(p, n);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1 chk("rnd_rst_locked", 32'(locked), 0);
        rst = 1'b1;
      end
    end
    clr_err = 1'b0;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
